alu_exec_unit: RTL and testbench

- Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder.
- Executes the selected operation on two WIDTH-bit operands, with a start/busy/done handshake toward the datapath controller.
- ADD, SUB, AND, OR and SLT complete in one cycle; SRL runs bit-serially, one bit position per cycle.
- Sits in the EX stage between the register-file/immediate muxes and the writeback/branch logic.

---
 rtl/alu_exec_unit_if.sv | 31 +++
 rtl/alu_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
// Request/response bundle between the EX-stage controller and alu_exec_unit.
//   master : controller side, drives start/ALUsignal/a/b/shamt and observes
//            busy/done/result/zero/overflow.
//   slave  : execution unit side, the mirror image.
// WIDTH and SHAMT_W must match the parameters of the attached alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [3:0]         ALUsignal;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;

  modport master (
    output start, ALUsignal, a, b, shamt,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, ALUsignal, a, b, shamt,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Multi-cycle EX-stage execution unit. ADD, SUB, AND, OR, SLT (and SRL by 0)
// finish in one cycle; SRL by n>0 shifts one bit per cycle and finishes after
// n+1 cycles. Unknown operation codes execute as ADD.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_exec_unit_if.slave
//           start/ALUsignal/a/b/shamt in, busy/done/result/zero/overflow out.
//           Inputs are sampled only when busy=0 and start=1; done is a
//           one-cycle pulse and result/zero/overflow hold until the next one.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b1010;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t             state,  state_n;
  logic [WIDTH-1:0]   acc,    acc_n;
  logic [SHAMT_W-1:0] cnt,    cnt_n;
  logic [WIDTH-1:0]   res_q,  res_n;
  logic               zero_q, zero_n;
  logic               ovf_q,  ovf_n;
  logic               done_q, done_n;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic               slt_bit;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   acc_shr;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  // Signed overflow: the result sign disagrees with a when the operands
  // (after negating b for SUB) share a's sign.
  assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1]  != bus.a[WIDTH-1]);
  assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

  // Signed compare directly rather than via diff's sign bit, so SLT stays
  // correct when a-b overflows.
  assign slt_bit = $signed(bus.a) < $signed(bus.b);

  assign acc_shr = acc >> 1;

  // Single-cycle datapath; SRL here only covers the shamt=0 case.
  always_comb begin
    alu_res = sum;
    alu_ovf = add_ovf;
    case (bus.ALUsignal)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_AND: begin
        alu_res = bus.a & bus.b;
        alu_ovf = 1'b0;
      end
      OP_OR: begin
        alu_res = bus.a | bus.b;
        alu_ovf = 1'b0;
      end
      OP_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
        alu_ovf = 1'b0;
      end
      OP_SRL: begin
        alu_res = bus.a;
        alu_ovf = 1'b0;
      end
      default: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
    endcase
  end

  // Next-state and next-output logic. done defaults low so it only pulses
  // for the one cycle following a completion.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    res_n   = res_q;
    zero_n  = zero_q;
    ovf_n   = ovf_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.ALUsignal == OP_SRL && bus.shamt != '0) begin
            acc_n   = bus.a;
            cnt_n   = bus.shamt;
            state_n = SHIFT;
          end else begin
            res_n  = alu_res;
            zero_n = (alu_res == '0);
            ovf_n  = alu_ovf;
            done_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_n = acc_shr;
        cnt_n = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          res_n   = acc_shr;
          zero_n  = (acc_shr == '0);
          ovf_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      res_q  <= res_n;
      zero_q <= zero_n;
      ovf_q  <= ovf_n;
      done_q <= done_n;
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed bench for alu_exec_unit: a table of single-cycle vectors plus
// hand-written sequences for SRL timing, busy-ignore, back-to-back issue and
// reset in the middle of a shift.
module tb_alu_exec_unit;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b1010;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs [16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge: presents a request, lets the next rising edge
  // capture it, drops start, and returns at the following negedge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh);
    bus.start     = 1'b1;
    bus.ALUsignal = op;
    bus.a         = a;
    bus.b         = b;
    bus.shamt     = sh;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.ALUsignal = 4'b0000;
    bus.a         = 32'hDEAD_BEEF;
    bus.b         = 32'h1234_5678;
    bus.shamt     = 5'd0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_seen;

    vecs[0]  = '{OP_ADD, 32'd7,          32'd5,          5'd0,  32'd12,         1'b0, 1'b0};
    vecs[1]  = '{OP_SUB, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'h8000_0000,  1'b0, 1'b1};
    vecs[2]  = '{OP_SUB, 32'd5,          32'd5,          5'd0,  32'd0,          1'b1, 1'b0};
    vecs[3]  = '{OP_SLT, 32'h8000_0000,  32'd1,          5'd0,  32'd1,          1'b0, 1'b0};
    vecs[4]  = '{OP_SLT, 32'd1,          32'h8000_0000,  5'd0,  32'd0,          1'b1, 1'b0};
    vecs[5]  = '{OP_AND, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  32'h0000_00F0,  1'b0, 1'b0};
    vecs[6]  = '{OP_OR,  32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  32'h0000_FFF0,  1'b0, 1'b0};
    vecs[7]  = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b0, 1'b1};
    vecs[8]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0};
    vecs[9]  = '{OP_SUB, 32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b0, 1'b1};
    vecs[10] = '{OP_SLT, 32'h7FFF_FFFF,  32'h8000_0000,  5'd0,  32'd0,          1'b1, 1'b0};
    vecs[11] = '{OP_SLT, 32'h8000_0000,  32'h7FFF_FFFF,  5'd0,  32'd1,          1'b0, 1'b0};
    vecs[12] = '{OP_SLT, 32'hFFFF_FFFF,  32'd0,          5'd0,  32'd1,          1'b0, 1'b0};
    vecs[13] = '{4'b1111, 32'd3,         32'd4,          5'd0,  32'd7,          1'b0, 1'b0};
    vecs[14] = '{OP_SRL, 32'h0000_1234,  32'hFFFF_FFFF,  5'd0,  32'h0000_1234,  1'b0, 1'b0};
    vecs[15] = '{OP_AND, 32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'h8000_0000,  1'b0, 1'b0};

    bus.start     = 1'b0;
    bus.ALUsignal = 4'b0000;
    bus.a         = '0;
    bus.b         = '0;
    bus.shamt     = '0;
    rst_n         = 1'b1;
    #2 rst_n      = 1'b0;
    #1;
    checkOutput("reset busy",     32'(bus.busy),     32'd0);
    checkOutput("reset done",     32'(bus.done),     32'd0);
    checkOutput("reset result",   bus.result,        32'd0);
    checkOutput("reset zero",     32'(bus.zero),     32'd1);
    checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      checkOutput($sformatf("vec%0d done", i),     32'(bus.done),     32'd1);
      checkOutput($sformatf("vec%0d busy", i),     32'(bus.busy),     32'd0);
      checkOutput($sformatf("vec%0d result", i),   bus.result,        vecs[i].res);
      checkOutput($sformatf("vec%0d zero", i),     32'(bus.zero),     32'(vecs[i].z));
      checkOutput($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].v));
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse", i), 32'(bus.done), 32'd0);
      checkOutput($sformatf("vec%0d result held", i), bus.result,   vecs[i].res);
    end

    // SRL by 4: busy for cycles 1..4, done in cycle 5. An ADD request in
    // cycle 2 must be ignored.
    applyStimulus(OP_SRL, 32'h8000_0000, 32'd0, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("srl4 busy c%0d", k), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("srl4 done c%0d", k), 32'(bus.done), 32'd0);
      if (k == 2) begin
        applyStimulus(OP_ADD, 32'd1, 32'd1, 5'd0);
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("srl4 done",     32'(bus.done),     32'd1);
    checkOutput("srl4 busy end", 32'(bus.busy),     32'd0);
    checkOutput("srl4 result",   bus.result,        32'h0800_0000);
    checkOutput("srl4 zero",     32'(bus.zero),     32'd0);
    checkOutput("srl4 overflow", 32'(bus.overflow), 32'd0);

    // Back-to-back: new request issued in the SRL's done cycle.
    applyStimulus(OP_AND, 32'h0000_00FF, 32'h0000_000F, 5'd0);
    checkOutput("b2b done",   32'(bus.done), 32'd1);
    checkOutput("b2b result", bus.result,    32'h0000_000F);
    @(negedge clk);
    checkOutput("b2b done pulse", 32'(bus.done), 32'd0);

    // Reset in the middle of a 20-bit shift.
    applyStimulus(OP_SRL, 32'hFFFF_FFFF, 32'd0, 5'd20);
    checkOutput("srl20 busy", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy",   32'(bus.busy), 32'd0);
    checkOutput("midreset result", bus.result,    32'd0);
    checkOutput("midreset zero",   32'(bus.zero), 32'd1);
    checkOutput("midreset done",   32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checkOutput("midreset no done", 32'(done_seen), 32'd0);
    checkOutput("midreset result held", bus.result, 32'd0);

    applyStimulus(OP_ADD, 32'd7, 32'd5, 5'd0);
    checkOutput("post-reset add done",   32'(bus.done), 32'd1);
    checkOutput("post-reset add result", bus.result,    32'd12);
    checkOutput("post-reset add zero",   32'(bus.zero), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
